// File: rtl/imm_encoder.sv
// Immediate encoder: range-checks an immediate and packs it into a base instruction word.
// Also expands the LI pseudo-op into ADDI, LUI or a two-beat LUI/ADDI pair.
module imm_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [31:0]          in_base,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic                 out_last,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned XW      = 32;
    localparam int unsigned HI_W    = 20;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [2:0]  F3_ADDI = 3'b000;

    typedef enum logic {
        S_IDLE,
        S_SECOND
    } state_e;

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [XW-1:0]          instr_q, instr_d;
    logic                   err_q, err_d;
    logic                   last_q, last_d;
    logic [XW-1:0]          pend_q, pend_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [XW-1:0]          enc_instr;
    logic                   enc_err;
    logic                   enc_two;
    logic [XW-1:0]          enc_pend;
    logic [HI_W-1:0]        li_hi;
    logic [11:0]            li_lo;
    logic [4:0]             li_rd;
    logic                   accept;
    logic                   fire_out;

    assign li_hi    = HI_W'((in_imm + 32'h0000_0800) >> 12);
    assign li_lo    = in_imm[11:0];
    assign li_rd    = in_base[11:7];
    assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire_out = valid_q && out_ready;

    // Format-specific packing and range check of the incoming request
    always_comb begin
        enc_instr = in_base;
        enc_err   = 1'b0;
        enc_two   = 1'b0;
        enc_pend  = '0;
        case (in_sel)
            3'd0: begin
                enc_instr = {in_imm[11:0], in_base[19:0]};
                enc_err   = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
            end
            3'd1: begin
                enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
                enc_err   = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
            end
            3'd2: begin
                enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1],
                             in_imm[11], in_base[6:0]};
                enc_err   = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
            end
            3'd3: begin
                enc_instr = {in_imm[31:12], in_base[11:0]};
                enc_err   = in_imm[11:0] != 12'd0;
            end
            3'd4: begin
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_base[11:0]};
                enc_err   = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
            end
            3'd5: begin
                if (li_hi == '0) begin
                    enc_instr = {li_lo, 5'd0, F3_ADDI, li_rd, OP_IMM};
                end else if (li_lo == 12'd0) begin
                    enc_instr = {li_hi, li_rd, OP_LUI};
                end else begin
                    enc_instr = {li_hi, li_rd, OP_LUI};
                    enc_two   = 1'b1;
                    enc_pend  = {li_lo, li_rd, F3_ADDI, li_rd, OP_IMM};
                end
            end
            default: begin
                enc_instr = in_base;
                enc_err   = 1'b1;
            end
        endcase
    end

    // Next-state: new request, pending ADDI beat, or drain of the output register
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        err_d     = err_q;
        last_d    = last_q;
        pend_d    = pend_q;
        err_cnt_d = err_cnt_q;

        if (accept) begin
            valid_d = 1'b1;
            instr_d = enc_instr;
            err_d   = enc_err;
            last_d  = !enc_two;
            if (enc_two) begin
                state_d = S_SECOND;
                pend_d  = enc_pend;
            end
        end else if (state_q == S_SECOND && fire_out) begin
            valid_d = 1'b1;
            instr_d = pend_q;
            err_d   = 1'b0;
            last_d  = 1'b1;
            state_d = S_IDLE;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end

        if (fire_out && err_q && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
            pend_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_last  = last_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, scoreboard on output beats, corner sequences.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [2:0]  in_sel;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_instr, out_instr2;
    logic        out_err, out_err2;
    logic        out_last, out_last2;
    logic [7:0]  err_count;
    logic [1:0]  err_count2;

    imm_encoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_base(in_base), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .out_last(out_last), .err_count(err_count)
    );

    imm_encoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_sel(in_sel), .in_base(in_base), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_err(out_err2), .out_last(out_last2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] imm;
        int          nb;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int unsigned err_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: compare each handshaken beat with the oldest expected one
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", out_instr, 32'hxxxx_xxxx);
            end else begin
                beat_t b;
                b = sb.pop_front();
                chk("beat_instr", out_instr, b.instr);
                chk("beat_err", 32'(out_err), 32'(b.err));
                chk("beat_last", 32'(out_last), 32'(b.last));
                if (b.err && err_exp < 255) err_exp++;
            end
        end
    end

    task automatic send(input vec_t v, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        in_sel   = v.sel;
        in_base  = v.base;
        in_imm   = v.imm;
        n = 0;
        acc_cyc = -1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(n), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        if (v.nb == 2) begin
            sb.push_back('{instr: v.i0, err: 1'b0, last: 1'b0});
            sb.push_back('{instr: v.i1, err: 1'b0, last: 1'b1});
        end else begin
            sb.push_back('{instr: v.i0, err: v.err, last: 1'b1});
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat2(input int unsigned e);
        return (e > 3) ? 32'd3 : 32'(e);
    endfunction

    vec_t vecs[16];
    int   acc;
    int   acc_first;
    int   acc_last;

    initial begin
        vecs[0]  = '{3'd2, 32'h00208063, 32'hFFFFFFFC, 1, 32'hFE208EE3, 32'h0, 1'b0};
        vecs[1]  = '{3'd5, 32'hFFFFF0FF, 32'h00000FFF, 2, 32'h000010B7, 32'hFFF08093, 1'b0};
        vecs[2]  = '{3'd0, 32'h00000093, 32'h00000800, 1, 32'h80000093, 32'h0, 1'b1};
        vecs[3]  = '{3'd4, 32'h0000006F, 32'h00000003, 1, 32'h0020006F, 32'h0, 1'b1};
        vecs[4]  = '{3'd0, 32'h00000093, 32'hFFFFF800, 1, 32'h80000093, 32'h0, 1'b0};
        vecs[5]  = '{3'd1, 32'h00112023, 32'h000007FF, 1, 32'h7E112FA3, 32'h0, 1'b0};
        vecs[6]  = '{3'd3, 32'h000002B7, 32'hABCDE000, 1, 32'hABCDE2B7, 32'h0, 1'b0};
        vecs[7]  = '{3'd3, 32'h000002B7, 32'hABCDE001, 1, 32'hABCDE2B7, 32'h0, 1'b1};
        vecs[8]  = '{3'd2, 32'h00208063, 32'h00001000, 1, 32'h80208063, 32'h0, 1'b1};
        vecs[9]  = '{3'd4, 32'h000000EF, 32'h000FFFFE, 1, 32'h7FFFF0EF, 32'h0, 1'b0};
        vecs[10] = '{3'd5, 32'h00000100, 32'h000007FF, 1, 32'h7FF00113, 32'h0, 1'b0};
        vecs[11] = '{3'd5, 32'h00000180, 32'h12345000, 1, 32'h123451B7, 32'h0, 1'b0};
        vecs[12] = '{3'd6, 32'hDEADBEEF, 32'h00000000, 1, 32'hDEADBEEF, 32'h0, 1'b1};
        vecs[13] = '{3'd7, 32'h01234567, 32'h00000000, 1, 32'h01234567, 32'h0, 1'b1};
        vecs[14] = '{3'd5, 32'h00000080, 32'hFFFFF800, 1, 32'h80000093, 32'h0, 1'b0};
        vecs[15] = '{3'd5, 32'h00000200, 32'hFFFFFFFF, 1, 32'hFFF00213, 32'h0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_base   = 32'h0;
        in_imm    = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, one request at a time, error counters checked after each
        for (int i = 0; i < 16; i++) begin
            send(vecs[i], acc);
            drain();
            chk("err_count", 32'(err_count), 32'(err_exp));
            chk("err_count_sat2", 32'(err_count2), sat2(err_exp));
        end

        // LI two-beat expansion with a stalled sink: beat 1 must hold
        out_ready = 1'b0;
        send('{3'd5, 32'h00000280, 32'h12345678, 2, 32'h123452B7, 32'h67828293, 1'b0}, acc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_instr", out_instr, 32'h123452B7);
            chk("stall_last", 32'(out_last), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Back-to-back stream: one accept per cycle with the sink always ready
        acc_first = -1;
        acc_last  = -1;
        for (int i = 0; i < 8; i++) begin
            send('{3'd0, 32'h00008013, 32'(i * 3), 1,
                   32'h00008013 | (32'(i * 3) << 20), 32'h0, 1'b0}, acc);
            if (i == 0) acc_first = acc;
            acc_last = acc;
        end
        drain();
        chk("stream_span", 32'(acc_last - acc_first), 32'd7);

        // Reset while the pending ADDI beat is waiting
        out_ready = 1'b0;
        send('{3'd5, 32'h00000280, 32'h12345678, 2, 32'h123452B7, 32'h67828293, 1'b0}, acc);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        sb.delete();
        err_exp = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_beat", 32'(out_valid), 32'd0);
        end
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_errcnt", 32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
